// File: rtl/aes_key_unroller.sv
// aes_key_unroller: inverse AES-128 key schedule, emits round keys 10..0.
// Optional replay cache is enabled by defining AES_KEY_UNROLL_CACHE_EN.

module aes_sbox (
    input  logic [7:0] value,
    output logic [7:0] result
);
    // Forward AES S-box; entry 0x00 sits in the top byte of the table.
    localparam logic [2047:0] TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // (255 - value) * 8 selects the byte for this input.
    assign result = TABLE[{~value, 3'b000} +: 8];
endmodule

module aes_key_unroller (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [0:127] last_key,
    input  logic         replay,
    input  logic         key_ready,
    output logic         key_valid,
    output logic [0:127] round_key,
    output logic [0:3]   round_out,
    output logic         busy,
    output logic         done
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_STREAM = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    logic [1:0]   state;
    logic [0:127] key;
    logic [3:0]   round;
    logic         fire;
    logic         replay_go;
    logic [0:127] replay_key;
    logic [0:127] prev_key;
    logic [0:127] next_key;

    logic [31:0] w0, w1, w2, w3;
    logic [31:0] p0, p1, p2, p3;
    logic [31:0] rot, sub;
    logic [7:0]  rc;

    assign fire = (state == S_STREAM) && key_ready;

    assign w0 = key[0:31];
    assign w1 = key[32:63];
    assign w2 = key[64:95];
    assign w3 = key[96:127];

    assign p3 = w3 ^ w2;
    assign p2 = w2 ^ w1;
    assign p1 = w1 ^ w0;

    assign rot = {p3[23:0], p3[31:24]};

    aes_sbox u_sbox0 (.value(rot[31:24]), .result(sub[31:24]));
    aes_sbox u_sbox1 (.value(rot[23:16]), .result(sub[23:16]));
    aes_sbox u_sbox2 (.value(rot[15:8]),  .result(sub[15:8]));
    aes_sbox u_sbox3 (.value(rot[7:0]),   .result(sub[7:0]));

    // Round constant belonging to the round currently being undone.
    always_comb begin
        rc = 8'h00;
        case (round)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
    end

    assign p0       = w0 ^ sub ^ {rc, 24'h000000};
    assign prev_key = {p0, p1, p2, p3};

`ifdef AES_KEY_UNROLL_CACHE_EN
    logic [0:127] cache [0:10];
    logic         cache_valid;
    logic         from_cache;
    logic [3:0]   prev_round;

    assign prev_round = round - 4'd1;
    assign next_key   = from_cache ? cache[prev_round] : prev_key;
    assign replay_go  = replay && cache_valid;
    assign replay_key = cache[10];

    // Capture every computed key as it is handed to the consumer.
    always_ff @(posedge clk) begin
        if (fire && !from_cache) begin
            cache[round] <= key;
        end
    end

    // Cache validity and source selection for the running sequence.
    always_ff @(posedge clk) begin
        if (rst) begin
            cache_valid <= 1'b0;
            from_cache  <= 1'b0;
        end else begin
            if (state == S_IDLE && start) begin
                cache_valid <= 1'b0;
                from_cache  <= 1'b0;
            end else if (state == S_IDLE && replay_go) begin
                from_cache  <= 1'b1;
            end
            if (fire && round == 4'd0 && !from_cache) begin
                cache_valid <= 1'b1;
            end
        end
    end
`else
    logic unused_replay;

    assign unused_replay = replay;
    assign next_key      = prev_key;
    assign replay_go     = 1'b0;
    assign replay_key    = '0;
`endif

    // Control FSM with the key and round registers it steers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            key   <= '0;
            round <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        key   <= last_key;
                        round <= 4'd10;
                        state <= S_STREAM;
                    end else if (replay_go) begin
                        key   <= replay_key;
                        round <= 4'd10;
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (fire) begin
                        if (round == 4'd0) begin
                            state <= S_DONE;
                        end else begin
                            key   <= next_key;
                            round <= round - 4'd1;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign key_valid = (state == S_STREAM);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);
    assign round_key = key;
    assign round_out = round;
endmodule

// File: tb/tb_aes_key_unroller.sv
// Directed bench for aes_key_unroller using the FIPS-197 AES-128 schedule.
// Replay checks follow AES_KEY_UNROLL_CACHE_EN.
`timescale 1ns/1ps
module tb_aes_key_unroller;
    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [0:127] last_key;
    logic         replay;
    logic         key_ready;
    logic         key_valid;
    logic [0:127] round_key;
    logic [0:3]   round_out;
    logic         busy;
    logic         done;

    logic [0:127] exp_key [0:10];
    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    aes_key_unroller dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .last_key  (last_key),
        .replay    (replay),
        .key_ready (key_ready),
        .key_valid (key_valid),
        .round_key (round_key),
        .round_out (round_out),
        .busy      (busy),
        .done      (done)
    );

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; replay = 1'b0;
        key_ready = 1'b0; last_key = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (key_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset key_valid: got %b want 0", key_valid);
        end
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL reset busy: got %b want 0", busy);
        end
        n_cmp++;
        if (done !== 1'b0) begin
            n_bad++; $display("FAIL reset done: got %b want 0", done);
        end
        n_cmp++;
        if (round_key !== 128'h0) begin
            n_bad++; $display("FAIL reset round_key: got %h want 0", round_key);
        end
        n_cmp++;
        if (round_out !== 4'd0) begin
            n_bad++; $display("FAIL reset round_out: got %0d want 0", round_out);
        end
    endtask

    task automatic test_basic();
        int done_at;
        done_at = 0;
        @(negedge clk);
        start = 1'b1; last_key = exp_key[10]; key_ready = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= 11) begin
                n_cmp++;
                if (key_valid !== 1'b1 || round_out !== 4'(11 - c) ||
                    round_key !== exp_key[11 - c]) begin
                    n_bad++;
                    $display("FAIL basic key c=%0d: got v=%b r=%0d %h want v=1 r=%0d %h",
                             c, key_valid, round_out, round_key, 11 - c, exp_key[11 - c]);
                end
            end
            if (done === 1'b1 && done_at == 0) done_at = c;
            if (c == 13) begin
                n_cmp++;
                if (busy !== 1'b0 || key_valid !== 1'b0) begin
                    n_bad++;
                    $display("FAIL basic idle after done: got busy=%b v=%b want 0 0",
                             busy, key_valid);
                end
            end
        end
        n_cmp++;
        if (done_at != 12) begin
            n_bad++; $display("FAIL basic done latency: got %0d want 12", done_at);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        start = 1'b1; last_key = exp_key[10]; key_ready = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        n_cmp++;
        if (done !== 1'b1) begin
            n_bad++; $display("FAIL b2b first done: got %b want 1", done);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0) begin
            n_bad++; $display("FAIL b2b busy after done: got %b want 0", busy);
        end
        start = 1'b1; last_key = exp_key[10];
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= 11) begin
                n_cmp++;
                if (key_valid !== 1'b1 || round_out !== 4'(11 - c) ||
                    round_key !== exp_key[11 - c]) begin
                    n_bad++;
                    $display("FAIL b2b key c=%0d: got v=%b r=%0d %h want r=%0d %h",
                             c, key_valid, round_out, round_key, 11 - c, exp_key[11 - c]);
                end
            end else begin
                n_cmp++;
                if (done !== 1'b1) begin
                    n_bad++; $display("FAIL b2b second done: got %b want 1", done);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        int idx;
        bit stalled;
        bit saw_done;
        idx = 0; stalled = 1'b0; saw_done = 1'b0;
        @(negedge clk);
        start = 1'b1; last_key = exp_key[10]; key_ready = 1'b1;
        for (int c = 0; c < 300 && idx < 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (!stalled && key_valid === 1'b1 && round_out === 4'd7) begin
                key_ready = 1'b0;
                for (int s = 0; s < 5; s++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (key_valid !== 1'b1 || round_out !== 4'd7 ||
                        round_key !== exp_key[7]) begin
                        n_bad++;
                        $display("FAIL stall hold s=%0d: got v=%b r=%0d %h want r=7 %h",
                                 s, key_valid, round_out, round_key, exp_key[7]);
                    end
                end
                stalled = 1'b1;
            end
            key_ready = stalled ? 1'($urandom_range(0, 1)) : 1'b1;
            if (key_valid === 1'b1 && key_ready) begin
                n_cmp++;
                if (round_out !== 4'(10 - idx) || round_key !== exp_key[10 - idx]) begin
                    n_bad++;
                    $display("FAIL stall order idx=%0d: got r=%0d %h want r=%0d %h",
                             idx, round_out, round_key, 10 - idx, exp_key[10 - idx]);
                end
                idx++;
            end
        end
        n_cmp++;
        if (idx != 11 || !stalled) begin
            n_bad++;
            $display("FAIL stall count: got %0d keys stalled=%b want 11 keys stalled=1",
                     idx, stalled);
        end
        key_ready = 1'b1;
        for (int c = 0; c < 4 && !saw_done; c++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        n_cmp++;
        if (!saw_done) begin
            n_bad++; $display("FAIL stall done: got no pulse want pulse");
        end
    endtask

    task automatic test_start_ignored();
        int idx;
        bit poked;
        idx = 0; poked = 1'b0;
        @(negedge clk);
        start = 1'b1; last_key = exp_key[10]; key_ready = 1'b1;
        for (int c = 0; c < 20 && idx < 11; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (key_valid === 1'b1) begin
                n_cmp++;
                if (round_out !== 4'(10 - idx) || round_key !== exp_key[10 - idx]) begin
                    n_bad++;
                    $display("FAIL ignore key idx=%0d: got r=%0d %h want r=%0d %h",
                             idx, round_out, round_key, 10 - idx, exp_key[10 - idx]);
                end
                if (!poked && round_out === 4'd4) begin
                    start = 1'b1; last_key = '0; poked = 1'b1;
                end
                idx++;
            end
        end
        @(negedge clk);
        start = 1'b0;
        n_cmp++;
        if (done !== 1'b1 || idx != 11) begin
            n_bad++;
            $display("FAIL ignore done: got done=%b keys=%0d want 1 11", done, idx);
        end
        @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || key_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL ignore idle: got busy=%b v=%b want 0 0", busy, key_valid);
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        int done_at;
        found = 1'b0; done_at = 0;
        @(negedge clk);
        start = 1'b1; last_key = exp_key[10]; key_ready = 1'b1;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (key_valid === 1'b1 && round_out === 4'd5) found = 1'b1;
        end
        n_cmp++;
        if (!found) begin
            n_bad++; $display("FAIL midrst reach round 5: got none want round 5");
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (key_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
            round_key !== 128'h0 || round_out !== 4'd0) begin
            n_bad++;
            $display("FAIL midrst outputs: got v=%b b=%b d=%b r=%0d %h want all 0",
                     key_valid, busy, done, round_out, round_key);
        end
        start = 1'b1; last_key = exp_key[10];
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= 11) begin
                n_cmp++;
                if (key_valid !== 1'b1 || round_out !== 4'(11 - c) ||
                    round_key !== exp_key[11 - c]) begin
                    n_bad++;
                    $display("FAIL midrst key c=%0d: got v=%b r=%0d %h want r=%0d %h",
                             c, key_valid, round_out, round_key, 11 - c, exp_key[11 - c]);
                end
            end
            if (done === 1'b1 && done_at == 0) done_at = c;
        end
        n_cmp++;
        if (done_at != 12) begin
            n_bad++; $display("FAIL midrst done latency: got %0d want 12", done_at);
        end
    endtask

`ifdef AES_KEY_UNROLL_CACHE_EN
    task automatic test_replay();
        int done_at;
        done_at = 0;
        @(negedge clk);
        replay = 1'b1; key_ready = 1'b1;
        for (int c = 1; c <= 13; c++) begin
            @(negedge clk);
            replay = 1'b0;
            if (c <= 11) begin
                n_cmp++;
                if (key_valid !== 1'b1 || round_out !== 4'(11 - c) ||
                    round_key !== exp_key[11 - c]) begin
                    n_bad++;
                    $display("FAIL replay key c=%0d: got v=%b r=%0d %h want r=%0d %h",
                             c, key_valid, round_out, round_key, 11 - c, exp_key[11 - c]);
                end
            end
            if (done === 1'b1 && done_at == 0) done_at = c;
        end
        n_cmp++;
        if (done_at != 12) begin
            n_bad++; $display("FAIL replay done latency: got %0d want 12", done_at);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; replay = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || key_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL replay after reset c=%0d: got busy=%b v=%b want 0 0",
                         c, busy, key_valid);
            end
        end
        replay = 1'b0;
    endtask
`else
    task automatic test_replay();
        @(negedge clk);
        replay = 1'b1; key_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if (busy !== 1'b0 || key_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL replay disabled c=%0d: got busy=%b v=%b want 0 0",
                         c, busy, key_valid);
            end
        end
        replay = 1'b0;
    endtask
`endif

    initial begin
        exp_key[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        exp_key[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
        exp_key[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
        exp_key[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
        exp_key[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
        exp_key[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
        exp_key[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
        exp_key[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
        exp_key[8]  = 128'head27321b58dbad2312bf5607f8d292f;
        exp_key[9]  = 128'hac7766f319fadc2128d12941575c006e;
        exp_key[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
        test_replay();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
